// File: rtl/eprisc_rom_arbiter.sv
// Two-requester arbiter for the 1024x32 boot ROM: combinational grant, one read per cycle,
// and tagged registered read data returned two cycles after each grant.
module eprisc_rom_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RR_MODE  = 0,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iCpuReq,
    input  logic [ADDR_W-1:0] iCpuAddr,
    output logic              oCpuGnt,
    output logic              oCpuValid,
    output logic [DATA_W-1:0] oCpuData,
    input  logic              iAuxReq,
    input  logic [ADDR_W-1:0] iAuxAddr,
    output logic              oAuxGnt,
    output logic              oAuxValid,
    output logic [DATA_W-1:0] oAuxData,
    output logic [ADDR_W-1:0] oRomAddr,
    output logic              oRomEnable,
    input  logic [DATA_W-1:0] iRomData
);

    typedef enum logic {
        OwnerCpu = 1'b0,
        OwnerAux = 1'b1
    } owner_e;

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    logic              cpu_gnt;
    logic              aux_gnt;

    logic [7:0]        wait_cnt_q, wait_cnt_d;
    owner_e            last_q, last_d;
    logic              s1_valid_q, s1_valid_d;
    owner_e            s1_owner_q, s1_owner_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic              aux_valid_q, aux_valid_d;
    logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
    logic [DATA_W-1:0] aux_data_q, aux_data_d;

    // Arbitration: purely combinational so the address is consumed in the request cycle.
    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (RR_MODE != 0) begin
            if (iCpuReq && iAuxReq) begin
                cpu_gnt = (last_q == OwnerAux);
                aux_gnt = (last_q == OwnerCpu);
            end else begin
                cpu_gnt = iCpuReq;
                aux_gnt = iAuxReq;
            end
        end else begin
            aux_gnt = iAuxReq && (!iCpuReq || (wait_cnt_q == MaxWait));
            cpu_gnt = iCpuReq && !aux_gnt;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (RR_MODE != 0) begin
            wait_cnt_d = '0;
        end else if (!iAuxReq || aux_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MaxWait) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        last_d = last_q;
        if (cpu_gnt) begin
            last_d = OwnerCpu;
        end else if (aux_gnt) begin
            last_d = OwnerAux;
        end

        oRomAddr = '0;
        if (cpu_gnt) begin
            oRomAddr = iCpuAddr;
        end else if (aux_gnt) begin
            oRomAddr = iAuxAddr;
        end

        s1_valid_d = cpu_gnt | aux_gnt;
        s1_owner_d = aux_gnt ? OwnerAux : OwnerCpu;

        // Stage 2: the ROM drives the bus in the stage-1 cycle; capture into the owner only.
        cpu_valid_d = s1_valid_q && (s1_owner_q == OwnerCpu);
        aux_valid_d = s1_valid_q && (s1_owner_q == OwnerAux);
        cpu_data_d  = cpu_valid_d ? iRomData : cpu_data_q;
        aux_data_d  = aux_valid_d ? iRomData : aux_data_q;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wait_cnt_q  <= '0;
            last_q      <= OwnerAux;
            s1_valid_q  <= 1'b0;
            s1_owner_q  <= OwnerCpu;
            cpu_valid_q <= 1'b0;
            aux_valid_q <= 1'b0;
            cpu_data_q  <= '0;
            aux_data_q  <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            s1_owner_q  <= s1_owner_d;
            cpu_valid_q <= cpu_valid_d;
            aux_valid_q <= aux_valid_d;
            cpu_data_q  <= cpu_data_d;
            aux_data_q  <= aux_data_d;
        end
    end

    assign oCpuGnt    = cpu_gnt;
    assign oAuxGnt    = aux_gnt;
    assign oRomEnable = s1_valid_q;
    assign oCpuValid  = cpu_valid_q;
    assign oAuxValid  = aux_valid_q;
    assign oCpuData   = cpu_data_q;
    assign oAuxData   = aux_data_q;

endmodule

// File: tb/tb_eprisc_rom_arbiter.sv
// Bench for eprisc_rom_arbiter: instance 0 in priority mode (MAX_WAIT=8), instance 1 round-robin,
// each with a registered-address ROM model; a scoreboard matches every valid to its grant.
module tb_eprisc_rom_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic          cpu_req  [2];
    logic [AW-1:0] cpu_addr [2];
    logic          cpu_gnt  [2];
    logic          cpu_valid[2];
    logic [DW-1:0] cpu_data [2];
    logic          aux_req  [2];
    logic [AW-1:0] aux_addr [2];
    logic          aux_gnt  [2];
    logic          aux_valid[2];
    logic [DW-1:0] aux_data [2];
    logic [AW-1:0] rom_addr [2];
    logic          rom_en   [2];
    logic [AW-1:0] rom_q    [2];
    logic [DW-1:0] rom_data0, rom_data1;

    typedef struct {
        int            inst;
        logic          owner;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 32'h21000410 ^ ({22'd0, a} * 32'h9E3779B1);
    endfunction

    // ROM model: registered address, data only while enabled (poison value otherwise).
    always @(posedge clk) begin
        rom_q[0] <= rom_addr[0];
        rom_q[1] <= rom_addr[1];
    end
    assign rom_data0 = rom_en[0] ? rom_word(rom_q[0]) : 32'hBAD0BAD0;
    assign rom_data1 = rom_en[1] ? rom_word(rom_q[1]) : 32'hBAD0BAD0;

    eprisc_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_WAIT(8)) u_dut0 (
        .iClk(clk), .iRst_n(rst_n),
        .iCpuReq(cpu_req[0]), .iCpuAddr(cpu_addr[0]), .oCpuGnt(cpu_gnt[0]),
        .oCpuValid(cpu_valid[0]), .oCpuData(cpu_data[0]),
        .iAuxReq(aux_req[0]), .iAuxAddr(aux_addr[0]), .oAuxGnt(aux_gnt[0]),
        .oAuxValid(aux_valid[0]), .oAuxData(aux_data[0]),
        .oRomAddr(rom_addr[0]), .oRomEnable(rom_en[0]), .iRomData(rom_data0)
    );

    eprisc_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_WAIT(8)) u_dut1 (
        .iClk(clk), .iRst_n(rst_n),
        .iCpuReq(cpu_req[1]), .iCpuAddr(cpu_addr[1]), .oCpuGnt(cpu_gnt[1]),
        .oCpuValid(cpu_valid[1]), .oCpuData(cpu_data[1]),
        .iAuxReq(aux_req[1]), .iAuxAddr(aux_addr[1]), .oAuxGnt(aux_gnt[1]),
        .oAuxValid(aux_valid[1]), .oAuxData(aux_data[1]),
        .oRomAddr(rom_addr[1]), .oRomEnable(rom_en[1]), .iRomData(rom_data1)
    );

    // Scoreboard consumer: every valid must match the oldest outstanding grant.
    exp_t          m_e;
    logic          m_own;
    logic [DW-1:0] m_dat;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cpu_valid[i] || aux_valid[i]) begin
                checks++;
                m_own = aux_valid[i];
                m_dat = m_own ? aux_data[i] : cpu_data[i];
                if (cpu_valid[i] && aux_valid[i]) begin
                    errors++;
                    $display("FAIL sb_both_valid inst=%0d cyc=%0d: got both valids, want one", i, cyc);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected inst=%0d cyc=%0d: got valid owner=%0b data=%h, want none",
                             i, cyc, m_own, m_dat);
                end else begin
                    m_e = sb.pop_front();
                    if (m_e.inst != i || m_e.owner !== m_own || m_e.data !== m_dat || m_e.due != cyc) begin
                        errors++;
                        $display("FAIL sb_read: got inst=%0d owner=%0b data=%h cyc=%0d, want inst=%0d owner=%0b data=%h cyc=%0d",
                                 i, m_own, m_dat, cyc, m_e.inst, m_e.owner, m_e.data, m_e.due);
                    end
                end
            end
        end
    end

    task automatic expect_read(input int inst, input logic owner, input logic [AW-1:0] a);
        exp_t e;
        e.inst  = inst;
        e.owner = owner;
        e.data  = rom_word(a);
        e.due   = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        next_cycle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d reads outstanding, want 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 1'b0; aux_req[i] = 1'b0; cpu_addr[i] = '0; aux_addr[i] = '0;
        end
        next_cycle();
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rom_en[i] !== 1'b0 || cpu_valid[i] !== 1'b0 || aux_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl inst=%0d: got en=%b cv=%b av=%b, want 0 0 0",
                         i, rom_en[i], cpu_valid[i], aux_valid[i]);
            end
            checks++;
            if (cpu_data[i] !== '0 || aux_data[i] !== '0) begin
                errors++;
                $display("FAIL reset_data inst=%0d: got cpu=%h aux=%h, want 0 0", i, cpu_data[i], aux_data[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (cpu_gnt[i] !== 1'b0 || aux_gnt[i] !== 1'b0 || rom_addr[i] !== '0) begin
                errors++;
                $display("FAIL reset_idle inst=%0d: got cg=%b ag=%b addr=%h, want 0 0 0",
                         i, cpu_gnt[i], aux_gnt[i], rom_addr[i]);
            end
        end
        next_cycle();
    endtask

    task automatic test_single_cpu();
        cpu_addr[0] = 10'h000;
        cpu_req[0]  = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_gnt[0] !== 1'b1 || aux_gnt[0] !== 1'b0 || rom_addr[0] !== 10'h000) begin
            errors++;
            $display("FAIL single_grant: got cg=%b ag=%b addr=%h, want 1 0 000", cpu_gnt[0], aux_gnt[0], rom_addr[0]);
        end
        expect_read(0, 1'b0, 10'h000);
        next_cycle();
        cpu_req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_en[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_enable: got %b, want 1", rom_en[0]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_valid[0] !== 1'b1 || cpu_data[0] !== 32'h21000410 || aux_valid[0] !== 1'b0 || rom_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_valid: got cv=%b data=%h av=%b en=%b, want 1 21000410 0 0",
                     cpu_valid[0], cpu_data[0], aux_valid[0], rom_en[0]);
        end
        drain("single");
        checks++;
        if (aux_data[0] !== '0) begin
            errors++;
            $display("FAIL single_aux_hold: got %h, want 0", aux_data[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 7; k++) begin
            cpu_req[0]  = (k < 5);
            cpu_addr[0] = AW'(k < 5 ? k : 0);
            @(negedge clk);
            checks++;
            if (cpu_gnt[0] !== (k < 5) || rom_en[0] !== (k >= 1 && k <= 5)) begin
                errors++;
                $display("FAIL b2b_cycle k=%0d: got gnt=%b en=%b, want %b %b",
                         k, cpu_gnt[0], rom_en[0], (k < 5), (k >= 1 && k <= 5));
            end
            if (k < 5) expect_read(0, 1'b0, AW'(k));
            next_cycle();
        end
        drain("b2b");
    endtask

    task automatic test_starvation();
        int   wcnt = 0;
        logic exp_aux;
        logic [AW-1:0] exp_addr;
        cpu_req[0]  = 1'b1;
        aux_req[0]  = 1'b1;
        cpu_addr[0] = AW'($urandom_range(0, 1023));
        aux_addr[0] = AW'($urandom_range(0, 1023));
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            exp_aux  = (wcnt == 8);
            exp_addr = exp_aux ? aux_addr[0] : cpu_addr[0];
            checks++;
            if (cpu_gnt[0] !== !exp_aux || aux_gnt[0] !== exp_aux || rom_addr[0] !== exp_addr) begin
                errors++;
                $display("FAIL starve k=%0d: got cg=%b ag=%b addr=%h, want %b %b %h",
                         k, cpu_gnt[0], aux_gnt[0], rom_addr[0], !exp_aux, exp_aux, exp_addr);
            end
            expect_read(0, exp_aux, exp_addr);
            wcnt = exp_aux ? 0 : (wcnt < 8 ? wcnt + 1 : 8);
            next_cycle();
            if (exp_aux) aux_addr[0] = AW'($urandom_range(0, 1023));
            else         cpu_addr[0] = AW'($urandom_range(0, 1023));
        end
        cpu_req[0] = 1'b0;
        aux_req[0] = 1'b0;
        drain("starve");
    endtask

    // bit1 = cpu request, bit0 = aux request
    task automatic test_aux_alone();
        logic [1:0] pat[$];
        int   wcnt = 0;
        logic exp_cpu, exp_aux;
        repeat (5)  pat.push_back(2'b01);
        repeat (4)  pat.push_back(2'b11);
        pat.push_back(2'b10);
        repeat (10) pat.push_back(2'b11);
        repeat (3)  pat.push_back(2'b01);
        cpu_addr[0] = AW'($urandom_range(0, 1023));
        aux_addr[0] = AW'($urandom_range(0, 1023));
        foreach (pat[k]) begin
            cpu_req[0] = pat[k][1];
            aux_req[0] = pat[k][0];
            @(negedge clk);
            exp_aux = pat[k][0] && (!pat[k][1] || wcnt == 8);
            exp_cpu = pat[k][1] && !exp_aux;
            checks++;
            if (cpu_gnt[0] !== exp_cpu || aux_gnt[0] !== exp_aux) begin
                errors++;
                $display("FAIL aux_alone k=%0d: got cg=%b ag=%b, want %b %b",
                         k, cpu_gnt[0], aux_gnt[0], exp_cpu, exp_aux);
            end
            if (exp_cpu) expect_read(0, 1'b0, cpu_addr[0]);
            if (exp_aux) expect_read(0, 1'b1, aux_addr[0]);
            wcnt = (!pat[k][0] || exp_aux) ? 0 : (wcnt < 8 ? wcnt + 1 : 8);
            next_cycle();
            if (exp_cpu) cpu_addr[0] = AW'($urandom_range(0, 1023));
            if (exp_aux) aux_addr[0] = AW'($urandom_range(0, 1023));
        end
        cpu_req[0] = 1'b0;
        aux_req[0] = 1'b0;
        drain("aux_alone");
    endtask

    task automatic test_round_robin();
        logic [1:0] pat[$];
        logic last = 1'b1;
        logic exp_cpu, exp_aux;
        logic [AW-1:0] exp_addr;
        repeat (6) pat.push_back(2'b11);
        repeat (2) pat.push_back(2'b01);
        repeat (3) pat.push_back(2'b11);
        pat.push_back(2'b10);
        repeat (2) pat.push_back(2'b11);
        cpu_addr[1] = AW'($urandom_range(0, 1023));
        aux_addr[1] = AW'($urandom_range(0, 1023));
        foreach (pat[k]) begin
            cpu_req[1] = pat[k][1];
            aux_req[1] = pat[k][0];
            @(negedge clk);
            exp_cpu  = (pat[k] == 2'b11) ? last : pat[k][1];
            exp_aux  = (pat[k] == 2'b11) ? !last : pat[k][0];
            exp_addr = exp_cpu ? cpu_addr[1] : aux_addr[1];
            checks++;
            if (cpu_gnt[1] !== exp_cpu || aux_gnt[1] !== exp_aux || rom_addr[1] !== exp_addr) begin
                errors++;
                $display("FAIL rr k=%0d: got cg=%b ag=%b addr=%h, want %b %b %h",
                         k, cpu_gnt[1], aux_gnt[1], rom_addr[1], exp_cpu, exp_aux, exp_addr);
            end
            expect_read(1, exp_aux, exp_addr);
            last = exp_aux;
            next_cycle();
            if (exp_cpu) cpu_addr[1] = AW'($urandom_range(0, 1023));
            else         aux_addr[1] = AW'($urandom_range(0, 1023));
        end
        cpu_req[1] = 1'b0;
        aux_req[1] = 1'b0;
        drain("rr");
    endtask

    task automatic test_reset_mid_read();
        cpu_addr[0] = 10'h155;
        cpu_req[0]  = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant: got %b, want 1", cpu_gnt[0]);
        end
        next_cycle();
        cpu_req[0] = 1'b0;
        rst_n      = 1'b0;
        #1;
        checks++;
        if (rom_en[0] !== 1'b0 || cpu_valid[0] !== 1'b0 || cpu_data[0] !== '0 || aux_data[0] !== '0) begin
            errors++;
            $display("FAIL midrst_clear: got en=%b cv=%b cd=%h ad=%h, want 0 0 0 0",
                     rom_en[0], cpu_valid[0], cpu_data[0], aux_data[0]);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_valid[0] !== 1'b0 || aux_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_valid k=%0d: got cv=%b av=%b, want 0 0", k, cpu_valid[0], aux_valid[0]);
            end
            next_cycle();
        end
        cpu_addr[0] = 10'h2AA;
        cpu_req[0]  = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_gnt[0] !== 1'b1 || rom_addr[0] !== 10'h2AA) begin
            errors++;
            $display("FAIL midrst_regrant: got gnt=%b addr=%h, want 1 2aa", cpu_gnt[0], rom_addr[0]);
        end
        expect_read(0, 1'b0, 10'h2AA);
        next_cycle();
        cpu_req[0] = 1'b0;
        drain("midrst");
    endtask

    initial begin
        test_reset();
        test_single_cpu();
        test_back_to_back();
        test_starvation();
        test_aux_alone();
        test_round_robin();
        test_reset_mid_read();
        repeat (3) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion by %0t, want completion", $time);
        $fatal(1, "timeout");
    end

endmodule
